// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the tx_frame serial transmitter.
// Defining TX_FRAME_TWO_STOP_EN adds a second stop bit (STOP2 state).
package tx_frame_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef TX_FRAME_TWO_STOP_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_STOP2
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;
`endif

endpackage : tx_frame_pkg

// File: rtl/tx_frame_ser.sv
// Shift register and bit counter for tx_frame_ctrl. Loads a word, then on each
// shift moves one bit towards the LSB; last_bit flags the final data bit.
module tx_frame_ser
    import tx_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             cur_bit,
    output logic             next_bit,
    output logic             last_bit
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt;

    assign shifted  = shreg >> 1;
    assign cur_bit  = shreg[0];
    // Bit that becomes the LSB after this shift, so the registered output can lead it.
    assign next_bit = shifted[0];
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg <= shifted;
            if (!last_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule : tx_frame_ser

// File: rtl/tx_frame_ctrl.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional
// parity, stop bit(s). TX_FRAME_TWO_STOP_EN selects two stop bits.
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             DONE
);

    tx_state_e state;
    logic      par_en_q;
    logic      par_bit_q;
    logic      load;
    logic      shift;
    logic      cur_bit;
    logic      next_bit;
    logic      last_bit;

    assign load  = (state == ST_IDLE) && DATA_VALID;
    assign shift = (state == ST_DATA);

    tx_frame_ser #(
        .WIDTH(WIDTH)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .load_data(P_DATA),
        .shift    (shift),
        .cur_bit  (cur_bit),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    // Outputs are assigned alongside the state they belong to, so they change
    // on the same edge that enters the new state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (DATA_VALID) begin
                        state     <= ST_START;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= (^P_DATA) ^ PAR_TYP;
                    end
                end
                ST_START: begin
                    state  <= ST_DATA;
                    TX_OUT <= cur_bit;
                end
                ST_DATA: begin
                    if (last_bit) begin
                        if (par_en_q) begin
                            state  <= ST_PARITY;
                            TX_OUT <= par_bit_q;
                        end else begin
                            state  <= ST_STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        TX_OUT <= next_bit;
                    end
                end
                ST_PARITY: begin
                    state  <= ST_STOP;
                    TX_OUT <= 1'b1;
                end
`ifdef TX_FRAME_TWO_STOP_EN
                ST_STOP: begin
                    state  <= ST_STOP2;
                    TX_OUT <= 1'b1;
                end
                ST_STOP2: begin
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                end
`else
                ST_STOP: begin
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule : tx_frame_ctrl

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: per-cycle expected {TX_OUT, BUSY, DONE}
// is queued when a frame is launched and compared on each falling edge.
module tb_tx_frame_ctrl;

`ifdef TX_FRAME_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    typedef struct {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    string cur_test = "";

    tx_frame_ctrl #(
        .WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push(input logic tx, input logic busy, input logic done);
        exp_t e;
        e.tx   = tx;
        e.busy = busy;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Drive one DATA_VALID pulse (taken on the next rising edge) and queue the frame.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        push(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) push(d[i], 1'b1, 1'b0);
        if (pen) push((^d) ^ ptyp, 1'b1, 1'b0);
        for (int i = 0; i < N_STOP; i++) push(1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1);
    endtask

    task automatic sample(output logic was_done);
        exp_t e;
        @(negedge CLK);
        cyc++;
        checks++;
        was_done = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s cyc%0d: scoreboard empty, got tx=%b busy=%b done=%b",
                     cur_test, cyc, TX_OUT, BUSY, DONE);
        end else begin
            e = exp_q.pop_front();
            was_done = e.done;
            if ({TX_OUT, BUSY, DONE} !== {e.tx, e.busy, e.done}) begin
                errors++;
                $display("FAIL %s cyc%0d: got tx=%b busy=%b done=%b, expected tx=%b busy=%b done=%b",
                         cur_test, cyc, TX_OUT, BUSY, DONE, e.tx, e.busy, e.done);
            end
        end
        DATA_VALID = 1'b0;
    endtask

    task automatic drain();
        logic d;
        while (exp_q.size() > 0) sample(d);
    endtask

    task automatic test_reset();
        logic d;
        cur_test = "reset";
        cyc = 0;
        RST = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA = 8'hFF;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        sample(d);
        DATA_VALID = 1'b1;
        sample(d);
        sample(d);
    endtask

    // Release reset and launch 0xA5 in the same cycle: first edge with valid must start it.
    task automatic test_even_parity();
        cur_test = "a5_even";
        cyc = 0;
        RST = 1'b1;
        start_frame(8'hA5, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_odd_parity();
        cur_test = "01_odd";
        cyc = 0;
        start_frame(8'h01, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_no_parity();
        cur_test = "ff_nopar";
        cyc = 0;
        start_frame(8'hFF, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic d;
        int   n;
        cur_test = "ignore_b2b";
        cyc = 0;
        n = 0;
        start_frame(8'hA5, 1'b1, 1'b0);
        d = 1'b0;
        while (!d) begin
            sample(d);
            n++;
            if (n == 4) begin
                P_DATA     = 8'h00;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b1;
                DATA_VALID = 1'b1;
            end
        end
        start_frame(8'h5A, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_abort();
        logic d;
        cur_test = "abort";
        cyc = 0;
        start_frame(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sample(d);
        exp_q.delete();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({TX_OUT, BUSY, DONE} !== 3'b100) begin
            errors++;
            $display("FAIL %s async: got tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
                     cur_test, TX_OUT, BUSY, DONE);
        end
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0);
        sample(d);
        RST = 1'b1;
        sample(d);
        sample(d);
        sample(d);
        start_frame(8'h3C, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_random();
        logic d;
        cur_test = "random_b2b";
        cyc = 0;
        for (int f = 0; f < 6; f++) begin
            start_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            d = 1'b0;
            while (!d) sample(d);
        end
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tx_frame_ctrl

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: bit-rate clock; one serial bit per cycle.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port P_DATA, input, WIDTH bits: parallel word to transmit.
REQ-005 The block SHALL have port DATA_VALID, input, 1 bit: P_DATA is valid this cycle.
REQ-006 The block SHALL have port PAR_EN, input, 1 bit: insert a parity bit in the frame.
REQ-007 The block SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have port TX_OUT, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, plus STOP2 when the macro in REQ-025 is defined; each state other than IDLE SHALL last exactly one CLK cycle per bit.
REQ-012 In IDLE, on a clock edge with DATA_VALID=1, the block SHALL latch P_DATA, PAR_EN and PAR_TYP and enter START at that same edge.
REQ-013 DATA_VALID SHALL be ignored in every state other than IDLE, and latched values SHALL NOT change mid-frame.
REQ-014 TX_OUT and BUSY SHALL be registered outputs that change on the edge that enters the new state; TX_OUT SHALL be 1 in IDLE, 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and STOP2.
REQ-015 The DATA state SHALL send bits LSB first, using a bit counter that is cleared on entry to DATA and counts 0 to WIDTH-1; the FSM SHALL exit DATA after bit WIDTH-1, with no wrap back into DATA.
REQ-016 From DATA, the FSM SHALL go to PARITY if the latched PAR_EN is 1, and to STOP otherwise.
REQ-017 The parity bit SHALL be the XOR reduction of the latched word when PAR_TYP=0, and its complement (XNOR reduction) when PAR_TYP=1.
REQ-018 BUSY SHALL be 1 from START through the last stop bit inclusive, and 0 in IDLE.
REQ-019 DONE SHALL be 1 for exactly one cycle, on the first IDLE cycle after the last stop bit.
REQ-020 A DATA_VALID asserted during that DONE cycle SHALL be accepted, so consecutive frames can run with no idle gap beyond that cycle.
REQ-021 The frame length SHALL be 1 + WIDTH + PAR_EN + number of stop bits cycles.

Reset
REQ-022 While RST=0, the FSM SHALL be in IDLE, with TX_OUT=1, BUSY=0, DONE=0, bit counter=0 and all latched registers=0.
REQ-023 Asserting RST in the middle of a frame SHALL abort that frame immediately (asynchronously), with no DONE pulse.
REQ-024 After RST is released, the first frame SHALL be accepted on the first edge at which DATA_VALID=1.

Configuration
REQ-025 With macro TX_FRAME_TWO_STOP_EN defined, the STOP2 state SHALL follow STOP, giving two stop bits per frame.
REQ-026 Without TX_FRAME_TWO_STOP_EN, STOP SHALL return directly to IDLE, and STOP2 SHALL NOT exist in the state encoding.

Structure
REQ-027 The state encoding type and the default WIDTH constant SHALL reside in the shared package tx_frame_pkg.
REQ-028 The shift register and bit counter SHALL be a sub-module named tx_frame_ser, with load, shift and last-bit interface signals; the FSM, parity and output mux SHALL reside in tx_frame_ctrl.

Verification
REQ-029 Bench SHALL drive P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 with one DATA_VALID cycle -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, BUSY high for those 11 cycles, then DONE for 1 cycle.
REQ-030 Bench SHALL drive P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit=0, frame length 11 cycles.
REQ-031 Bench SHALL drive P_DATA=0xFF, PAR_EN=0 -> TX_OUT = 0, then eight 1s, then 1 (10 cycles), with no PARITY state visited.
REQ-032 Bench SHALL pulse DATA_VALID with P_DATA=0x00 in cycle 4 of a 0xA5 frame -> pulse ignored and the 0xA5 frame is unchanged; a second valid asserted in the DONE cycle SHALL start a new START on the next cycle.
REQ-033 Bench SHALL assert RST in cycle 5 of a frame -> TX_OUT=1 and BUSY=0 immediately, no DONE pulse, and the next frame after release is correct.
REQ-034 Bench SHALL build with TX_FRAME_TWO_STOP_EN defined and send 0xA5 with parity -> 12-cycle frame ending in 1,1, with DONE on cycle 13.
